// File: rtl/router_ctrl_fsm.sv
// Control FSM for the N-output packet router: header decode, payload/parity sequencing,
// full-stall handling, bounded wait-for-empty and a drop path with a saturating counter.
module router_ctrl_fsm #(
  parameter int unsigned NUM_PORTS    = 3,
  parameter int unsigned ADDR_W       = $clog2(NUM_PORTS),
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned WAIT_TIMEOUT = 32,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [DATA_W-1:0]    datain,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_packet_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic [ADDR_W-1:0]    dest_sel,
  output logic                 drop_state,
  output logic [CNT_W-1:0]     drop_cnt
);

  typedef enum logic [8:0] {
    StDecode        = 9'h001,
    StWaitEmpty     = 9'h002,
    StLoadFirst     = 9'h004,
    StLoadData      = 9'h008,
    StLoadParity    = 9'h010,
    StFifoFull      = 9'h020,
    StLoadAfterFull = 9'h040,
    StCheckParity   = 9'h080,
    StDrop          = 9'h100
  } state_e;

  localparam int unsigned NumSel  = 1 << ADDR_W;
  localparam int unsigned WcntW   = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [WcntW-1:0] WaitLast =
      WcntW'((WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [WcntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]  dest_sel_q, dest_sel_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [ADDR_W-1:0]  addr;
  logic               addr_ok;
  logic [NumSel-1:0]  empty_ext;
  logic [NumSel-1:0]  srst_ext;
  logic               soft_hit;
  logic               unused_data;

  assign addr        = datain[ADDR_W-1:0];
  assign addr_ok     = 32'(addr) < NUM_PORTS;
  // Zero-padded so an out-of-range dest_sel never reads an empty or soft-reset flag.
  assign empty_ext   = NumSel'(fifo_empty);
  assign srst_ext    = NumSel'(soft_reset);
  assign soft_hit    = srst_ext[dest_sel_q];
  assign unused_data = ^datain;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StDecode: begin
        if (pkt_valid) begin
          if (!addr_ok)             state_d = StDrop;
          else if (empty_ext[addr]) state_d = StLoadFirst;
          else                      state_d = StWaitEmpty;
        end
      end
      StWaitEmpty: begin
        if (empty_ext[dest_sel_q]) begin
          state_d = StLoadFirst;
        end else if (WAIT_TIMEOUT != 0 && wait_cnt_q == WaitLast) begin
          state_d = StDrop;
        end
      end
      StLoadFirst:  state_d = StLoadData;
      StLoadData: begin
        if (fifo_full)       state_d = StFifoFull;
        else if (!pkt_valid) state_d = StLoadParity;
      end
      StFifoFull: begin
        if (!fifo_full) state_d = StLoadAfterFull;
      end
      StLoadAfterFull: begin
        if (parity_done)           state_d = StDecode;
        else if (low_packet_valid) state_d = StLoadParity;
        else                       state_d = StLoadData;
      end
      StLoadParity:  state_d = StCheckParity;
      StCheckParity: state_d = fifo_full ? StFifoFull : StDecode;
      StDrop: begin
        if (!pkt_valid) state_d = StDecode;
      end
      default: state_d = StDecode;
    endcase
    if (state_q != StDecode && soft_hit) state_d = StDecode;
  end

  always_comb begin
    wait_cnt_d = (state_q == StWaitEmpty) ? wait_cnt_q + 1'b1 : '0;
    dest_sel_d = (state_q == StDecode && pkt_valid) ? addr : dest_sel_q;
    drop_cnt_d = drop_cnt_q;
    if (state_d == StDrop && state_q != StDrop && drop_cnt_q != '1) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // Strobes are registered from the next state so they match the state they decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StDecode;
      wait_cnt_q    <= '0;
      dest_sel_q    <= '0;
      drop_cnt_q    <= '0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      drop_state    <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      dest_sel_q    <= dest_sel_d;
      drop_cnt_q    <= drop_cnt_d;
      detect_add    <= state_d == StDecode;
      lfd_state     <= state_d == StLoadFirst;
      ld_state      <= state_d == StLoadData;
      laf_state     <= state_d == StLoadAfterFull;
      full_state    <= state_d == StFifoFull;
      rst_int_reg   <= state_d == StCheckParity;
      drop_state    <= state_d == StDrop;
      write_enb_reg <= state_d inside {StLoadData, StLoadAfterFull, StLoadParity};
      busy          <= state_d inside {StWaitEmpty, StLoadFirst, StLoadParity, StFifoFull,
                                       StLoadAfterFull, StCheckParity};
    end
  end

  assign dest_sel = dest_sel_q;
  assign drop_cnt = drop_cnt_q;

endmodule
